usb_tx_serializer: RTL

Transmit-path serializer that sits directly upstream of the TX bit stuffer. It accepts packet bytes over a valid/ready handshake and prepends the 8-bit SYNC pattern. Bits go out LSB first, one per 12 MHz cycle, and the serializer stalls whenever the stuffer inserts a stuff bit. After the last bit is consumed it requests end-of-packet from the downstream line driver.

---
 rtl/usb_tx_serializer.sv | 138 +++++++++++++
 1 files changed

// File: rtl/usb_tx_serializer.sv
// USB full-speed transmit serializer: prepends SYNC, shifts packet bytes out LSB first
// toward the bit stuffer, stalls on stuff bits and requests EOP after the final bit.
module usb_tx_serializer #(
    parameter logic [7:0] SYNC_PATTERN = 8'h80
) (
    input  logic       clk12,
    input  logic       RST,
    input  logic       txStart,
    input  logic [7:0] txData,
    input  logic       txDataValid,
    input  logic       txIsLast,
    output logic       txDataReady,
    input  logic       stuffReady,
    output logic       bitOut,
    output logic       bitValid,
    output logic       eopReq,
    output logic       txUnderrun,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA,
        ST_EOP
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic       last_q, last_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] hold_data_q, hold_data_d;
    logic       hold_last_q, hold_last_d;
    logic       hold_full_q, hold_full_d;
    logic       ready_q, ready_d;
    logic       underrun_q, underrun_d;

    logic sending;
    logic consume;
    logic accept;

    assign sending = (state_q == ST_SYNC) || (state_q == ST_DATA);
    assign consume = sending && stuffReady;
    assign accept  = txDataValid && ready_q;

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        hold_data_d = hold_data_q;
        hold_last_d = hold_last_q;
        hold_full_d = hold_full_q;
        underrun_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (txStart) begin
                    state_d = ST_SYNC;
                    shift_d = SYNC_PATTERN;
                    cnt_d   = 3'd0;
                    last_d  = 1'b0;
                end
            end
            ST_SYNC, ST_DATA: begin
                if (consume) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        if ((state_q == ST_DATA) && last_q) begin
                            state_d = ST_EOP;
                        end else if (!hold_full_q) begin
                            // Byte due but none buffered: abort cleanly, nothing partial goes out.
                            state_d     = ST_EOP;
                            underrun_d  = 1'b1;
                            hold_data_d = 8'h00;
                            hold_last_d = 1'b0;
                        end else begin
                            state_d     = ST_DATA;
                            shift_d     = hold_data_q;
                            last_d      = hold_last_q;
                            hold_full_d = 1'b0;
                        end
                    end
                end
            end
            ST_EOP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A new byte wins over the reload that emptied the register in the same cycle.
        if (accept) begin
            hold_data_d = txData;
            hold_last_d = txIsLast;
            hold_full_d = 1'b1;
        end

        ready_d = !hold_full_d && (state_d != ST_EOP);
    end

    // NOTE: sequential state uses non-blocking assignments only; reset is asynchronous.
    always_ff @(posedge clk12 or negedge RST) begin
        if (!RST) begin
            state_q     <= ST_IDLE;
            shift_q     <= 8'h00;
            last_q      <= 1'b0;
            cnt_q       <= 3'd0;
            hold_data_q <= 8'h00;
            hold_last_q <= 1'b0;
            hold_full_q <= 1'b0;
            ready_q     <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            hold_data_q <= hold_data_d;
            hold_last_q <= hold_last_d;
            hold_full_q <= hold_full_d;
            ready_q     <= ready_d;
            underrun_q  <= underrun_d;
        end
    end

    assign txDataReady = ready_q;
    assign bitOut      = shift_q[0];
    assign bitValid    = sending;
    assign eopReq      = (state_q == ST_EOP);
    assign txUnderrun  = underrun_q;
    assign busy        = (state_q != ST_IDLE);

endmodule
